// File: rtl/sequential_fixed_fma_pkg.sv
// ransac_fixed: fixed-point types, FMA opcodes, FSM states and format helpers
package ransac_fixed;
  localparam int VALUE_BITS = 32;
  localparam int FRACTION_BITS = 16;
  typedef logic signed [VALUE_BITS-1:0] fixed_t;
  typedef enum logic [1:0] {
    FMA_OPCODE_POS_A_POS_C = 2'b00,
    FMA_OPCODE_POS_A_NEG_C = 2'b01,
    FMA_OPCODE_NEG_A_POS_C = 2'b10,
    FMA_OPCODE_NEG_A_NEG_C = 2'b11
  } fma_opcode_t;
  typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;
  function automatic int value_bits();
    return VALUE_BITS;
  endfunction
  function automatic int fraction_bits();
    return FRACTION_BITS;
  endfunction
  function automatic fixed_t one();
    return fixed_t'(1) <<< FRACTION_BITS;
  endfunction
  function automatic fixed_t max_fixed();
    return {1'b0, {(VALUE_BITS-1){1'b1}}};
  endfunction
  function automatic fixed_t min_fixed();
    return {1'b1, {(VALUE_BITS-1){1'b0}}};
  endfunction
endpackage

// File: rtl/sequential_fixed_fma_if.sv
// sequential_fixed_fma_if: FMA valid/ready request and result bundle
interface sequential_fixed_fma_if import ransac_fixed::*; ();
  logic input_valid;
  logic input_ready;
  fma_opcode_t opcode;
  fixed_t a;
  fixed_t b;
  fixed_t c;
  logic output_valid;
  fixed_t r;
  modport master(output input_valid, opcode, a, b, c, input input_ready, output_valid, r);
  modport slave(input input_valid, opcode, a, b, c, output input_ready, output_valid, r);
endinterface

// File: rtl/sequential_fixed_fma_shift_add_multiplier.sv
// shift_add_multiplier: unsigned width x width multiplier, step_bits of y per cycle
module shift_add_multiplier #(
  parameter int width = 32,
  parameter int step_bits = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [width-1:0]   x,
  input  logic [width-1:0]   y,
  output logic               done,
  output logic [2*width-1:0] product
);
  localparam int steps = width / step_bits;
  localparam int cw = $clog2(steps + 1);
  logic [2*width-1:0] addend;
  logic [width-1:0] mplier;
  logic [cw-1:0] count;
  assign done = count == cw'(1);
  // load on start, then add one shifted partial product per cycle
  always_ff @(posedge clock)
    if (reset) begin
      count <= '0;
      product <= '0;
    end else if (start) begin
      addend <= {{width{1'b0}}, x};
      mplier <= y;
      product <= '0;
      count <= cw'(steps);
    end else if (count != '0) begin
      product <= product + addend * (2*width)'(mplier[step_bits-1:0]);
      addend <= addend << step_bits;
      mplier <= mplier >> step_bits;
      count <= count - 1'b1;
    end
endmodule

// File: rtl/sequential_fixed_fma.sv
// sequential_fixed_fma: multi-cycle r = (+/-a*b) + (+/-c); RANSAC_FMA_SATURATE_EN clamps instead of wrapping
module sequential_fixed_fma import ransac_fixed::*; #(
  parameter int latency = value_bits() / 16
) (
  input logic clock,
  input logic reset,
  sequential_fixed_fma_if.slave bus
);
  localparam int W = value_bits();
  localparam int F = fraction_bits();
  state_t state, next;
  logic accept, done, neg_p, neg_c, unused;
  logic [W-1:0] a_mag, b_mag;
  logic [2*W-1:0] product;
  fixed_t c_q, res;
  logic signed [W+1:0] p_mag, p_term, c_ext, c_term, sum;
  assign accept = bus.input_valid && state == IDLE;
  assign bus.input_ready = state == IDLE;
  assign a_mag = bus.a[W-1] ? -bus.a : bus.a;
  assign b_mag = bus.b[W-1] ? -bus.b : bus.b;
  shift_add_multiplier #(.width(W), .step_bits(W / latency)) mult (
    .clock(clock), .reset(reset), .start(accept), .x(a_mag), .y(b_mag), .done(done), .product(product)
  );
  assign p_mag = product[W+F+1:F];
  assign p_term = neg_p ? -p_mag : p_mag;
  assign c_ext = {{2{c_q[W-1]}}, c_q};
  assign c_term = neg_c ? -c_ext : c_ext;
  assign sum = p_term + c_term;
`ifdef RANSAC_FMA_SATURATE_EN
  assign res = (sum[W+1:W-1] == 3'b000 || sum[W+1:W-1] == 3'b111) ? sum[W-1:0] : sum[W+1] ? min_fixed() : max_fixed();
  assign unused = ^{product[2*W-1:W+F+2], product[F-1:0]};
`else
  assign res = sum[W-1:0];
  assign unused = ^{product[2*W-1:W+F+2], product[F-1:0], sum[W+1:W]};
`endif
  // state register
  always_ff @(posedge clock)
    state <= reset ? IDLE : next;
  // IDLE waits for a request, MUL follows the multiplier, ADD lasts one cycle
  always_comb begin
    next = state;
    next = state == IDLE ? (bus.input_valid ? MUL : IDLE) : state == MUL ? (done ? ADD : MUL) : IDLE;
  end
  // latch sign selection and addend on accept
  always_ff @(posedge clock)
    if (accept) begin
      neg_p <= bus.a[W-1] ^ bus.b[W-1] ^ bus.opcode[1];
      neg_c <= bus.opcode[0];
      c_q <= bus.c;
    end
  // register the result and pulse output_valid as ADD completes
  always_ff @(posedge clock)
    if (reset) begin
      bus.output_valid <= 1'b0;
      bus.r <= '0;
    end else begin
      bus.output_valid <= state == ADD;
      if (state == ADD) bus.r <= res;
    end
endmodule
